// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz timing constants and the sync bundle type used by the
// raster generator and the video encoder.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int COORD_W  = 11;

    // Signals that must stay aligned with the encoder's registered pixel data.
    typedef struct packed {
        logic video;
        logic hs;
        logic vs;
    } sync_bus_t;

    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register with a synchronous reset value; depth 0 is a
// plain wire so callers can tune latency without restructuring.
module sync_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ok;
            assign unused_ok = ^{clk, rst, rst_val};
            assign dout      = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            always_comb begin
                stage_d[0] = din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rst) begin
                        stage_q[i] <= rst_val;
                    end else begin
                        stage_q[i] <= stage_d[i];
                    end
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing.sv
// Raster scan generator: pixel clock divider, x/y counters, pacing strobes and
// sync/blanking outputs delayed to match the encoder's pipeline.
module vga_timing #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int CLK_DIV  = 2,
    parameter int PIPE_DLY = 1,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [vga_pkg::COORD_W-1:0] x,
    output logic [vga_pkg::COORD_W-1:0] y,
    output logic                        px_tick,
    output logic                        line_tick,
    output logic                        frame_tick,
    output logic                        video_on,
    output logic                        hsync,
    output logic                        vsync
);

    import vga_pkg::*;

    localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = 4;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOT - 1);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;

    sync_bus_t sync_raw;
    sync_bus_t sync_out;
    sync_bus_t sync_idle;

    // x advances once per pixel period; y advances only on the last pixel of a line.
    always_comb begin
        div_d      = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        px_tick    = (div_q == DIV_LAST);
        line_tick  = px_tick && (x_q == X_LAST);
        frame_tick = line_tick && (y_q == Y_LAST);
        x_d        = x_q;
        y_d        = y_q;
        if (px_tick) begin
            x_d = (x_q == X_LAST) ? '0 : x_q + COORD_W'(1);
        end
        if (line_tick) begin
            y_d = (y_q == Y_LAST) ? '0 : y_q + COORD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    always_comb begin
        sync_raw.video = (x_q < COORD_W'(H_ACTIVE)) && (y_q < COORD_W'(V_ACTIVE));
        sync_raw.hs    = sync_level((x_q >= COORD_W'(HS_START)) && (x_q < COORD_W'(HS_END)), SYNC_POL);
        sync_raw.vs    = sync_level((y_q >= COORD_W'(VS_START)) && (y_q < COORD_W'(VS_END)), SYNC_POL);
        sync_idle.video = 1'b0;
        sync_idle.hs    = ~SYNC_POL;
        sync_idle.vs    = ~SYNC_POL;
    end

    sync_delay #(
        .DEPTH (PIPE_DLY),
        .WIDTH ($bits(sync_bus_t))
    ) u_sync_delay (
        .clk     (clk),
        .rst     (rst),
        .rst_val (sync_idle),
        .din     (sync_raw),
        .dout    (sync_out)
    );

    assign x        = x_q;
    assign y        = y_q;
    assign video_on = sync_out.video;
    assign hsync    = sync_out.hs;
    assign vsync    = sync_out.vs;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench: three differently configured instances are driven with
// random resets and compared every clk against a clock-count reference model.
`timescale 1ns/1ps
module tb_vga_timing;

    import vga_pkg::*;

    localparam int NI = 3;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        px;
        logic        line;
        logic        frame;
        logic        video;
        logic        hs;
        logic        vs;
    } obs_t;

    typedef struct packed {
        logic [1:0] inst;
        obs_t       obs;
    } exp_t;

    typedef struct {
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        int div, dly;
        bit pol;
    } cfg_t;

    logic          clk = 1'b0;
    logic [NI-1:0] rst = '1;
    logic [10:0]   xs [NI];
    logic [10:0]   ys [NI];
    logic          pxs [NI];
    logic          lns [NI];
    logic          frs [NI];
    logic          vids [NI];
    logic          hss [NI];
    logic          vss [NI];

    int   n_cnt [NI];
    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    always #10 clk = ~clk;

    vga_timing #(
        .CLK_DIV (2), .PIPE_DLY (1), .SYNC_POL (1'b0)
    ) u_dut_a (
        .clk (clk), .rst (rst[0]), .x (xs[0]), .y (ys[0]),
        .px_tick (pxs[0]), .line_tick (lns[0]), .frame_tick (frs[0]),
        .video_on (vids[0]), .hsync (hss[0]), .vsync (vss[0])
    );

    vga_timing #(
        .H_ACTIVE (10), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (5), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .CLK_DIV (1), .PIPE_DLY (0), .SYNC_POL (1'b1)
    ) u_dut_b (
        .clk (clk), .rst (rst[1]), .x (xs[1]), .y (ys[1]),
        .px_tick (pxs[1]), .line_tick (lns[1]), .frame_tick (frs[1]),
        .video_on (vids[1]), .hsync (hss[1]), .vsync (vss[1])
    );

    vga_timing #(
        .H_ACTIVE (12), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (2),
        .CLK_DIV (3), .PIPE_DLY (3), .SYNC_POL (1'b0)
    ) u_dut_c (
        .clk (clk), .rst (rst[2]), .x (xs[2]), .y (ys[2]),
        .px_tick (pxs[2]), .line_tick (lns[2]), .frame_tick (frs[2]),
        .video_on (vids[2]), .hsync (hss[2]), .vsync (vss[2])
    );

    function automatic cfg_t cfg_of(input int i);
        cfg_t c;
        case (i)
            0:       c = '{H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP, 2, 1, 1'b0};
            1:       c = '{10, 2, 3, 2, 5, 1, 2, 2, 1, 0, 1'b1};
            default: c = '{12, 2, 3, 3, 6, 2, 2, 2, 3, 3, 1'b0};
        endcase
        return c;
    endfunction

    // Expected outputs n clks after reset release, from the raster rules alone.
    function automatic obs_t model(input cfg_t c, input int n);
        obs_t o;
        int   htot, vtot, p, m, xm, ym;
        htot    = c.ha + c.hfp + c.hsw + c.hbp;
        vtot    = c.va + c.vfp + c.vsw + c.vbp;
        p       = n / c.div;
        o.x     = 11'(p % htot);
        o.y     = 11'((p / htot) % vtot);
        o.px    = ((n % c.div) == c.div - 1);
        o.line  = o.px && ((p % htot) == htot - 1);
        o.frame = o.line && (((p / htot) % vtot) == vtot - 1);
        if (n >= c.dly) begin
            m       = (n - c.dly) / c.div;
            xm      = m % htot;
            ym      = (m / htot) % vtot;
            o.video = (xm < c.ha) && (ym < c.va);
            o.hs    = (xm >= c.ha + c.hfp && xm < c.ha + c.hfp + c.hsw) ? c.pol : !c.pol;
            o.vs    = (ym >= c.va + c.vfp && ym < c.va + c.vfp + c.vsw) ? c.pol : !c.pol;
        end else begin
            o.video = 1'b0;
            o.hs    = !c.pol;
            o.vs    = !c.pol;
        end
        return o;
    endfunction

    function automatic obs_t actual(input int i);
        obs_t o;
        o = '{xs[i], ys[i], pxs[i], lns[i], frs[i], vids[i], hss[i], vss[i]};
        return o;
    endfunction

    task automatic applyStimulus(input int cycles, input int rst_cycles, input int rst_odds);
        exp_t e;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                n_cnt[i] = rst[i] ? 0 : n_cnt[i] + 1;
                e.inst   = 2'(i);
                e.obs    = model(cfg_of(i), n_cnt[i]);
                exp_q.push_back(e);
            end
            for (int i = 0; i < NI; i++) begin
                rst[i] = (k < rst_cycles) || (rst_odds > 0 && $urandom_range(rst_odds - 1) == 0);
            end
        end
    endtask

    task automatic checkOutput(input exp_t e);
        obs_t a;
        a = actual(int'(e.inst));
        checks++;
        if (a !== e.obs) begin
            errors++;
            $display("[TB] FAIL inst%0d t=%0t got x=%0d y=%0d px=%b ln=%b fr=%b vid=%b hs=%b vs=%b required x=%0d y=%0d px=%b ln=%b fr=%b vid=%b hs=%b vs=%b",
                     e.inst, $time, a.x, a.y, a.px, a.line, a.frame, a.video, a.hs, a.vs,
                     e.obs.x, e.obs.y, e.obs.px, e.obs.line, e.obs.frame, e.obs.video, e.obs.hs, e.obs.vs);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                checkOutput(exp_q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < NI; i++) n_cnt[i] = 0;
        $display("[TB] reset, then first full line of the 640x480 instance");
        applyStimulus(1700, 2, 0);
        $display("[TB] mid-line reset on all instances");
        applyStimulus(1, 1, 0);
        applyStimulus(2500, 0, 0);
        $display("[TB] random resets");
        applyStimulus(3000, 0, 1500);
        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
